ysyx_23060240_bpu: RTL and testbench

Branch prediction unit for the NPC front end: the predicting end of the conditional-branch path whose resolving end is the branch comparison unit in EXU. IFU queries it with the fetch PC and receives a registered taken/target prediction one cycle later. EXU returns the resolved outcome (comparator result, real target, predicted values carried down the pipe). The block updates a direct-mapped BTB plus 2-bit saturating counters and raises a one-cycle redirect on misprediction.

---
 rtl/ysyx_23060240_bpu.sv | 129 ++++++++++++
 tb/tb_ysyx_23060240_bpu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060240_bpu.sv
// ysyx_23060240_bpu: direct-mapped BTB with 2-bit saturating counters.
// IFU lookups return a registered taken/target prediction one cycle later.
// EXU updates train the tables and raise a one-cycle redirect on mispredict.
// Optional feature macro: YSYX_23060240_BPU_PERF_EN adds the perf_lookups,
// perf_branches and perf_mispred counter outputs.
module ysyx_23060240_bpu #(
  parameter int unsigned ENTRIES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
`ifdef YSYX_23060240_BPU_PERF_EN
  output logic [31:0] perf_lookups,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispred,
`endif
  output logic        flush_valid,
  output logic [31:0] flush_pc
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             req_hit;
  logic             req_pred;
  logic             upd_hit;
  logic             mispred;

  assign req_idx  = req_pc[IDX_W+1:2];
  assign req_tag  = req_pc[31:IDX_W+2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign upd_tag  = upd_pc[31:IDX_W+2];
  assign req_hit  = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign req_pred = req_hit & ctr_q[req_idx][1];
  assign upd_hit  = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  assign mispred  = upd_valid & ((upd_taken != upd_pred_taken) |
                                 (upd_taken & (upd_target != upd_pred_target)));

  // Valid bits and counters: cleared on reset, trained by resolved branches.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i[IDX_W-1:0]] <= 1'b0;
        ctr_q[i[IDX_W-1:0]]   <= 2'd1;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'd3) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
        end else begin
          if (ctr_q[upd_idx] != 2'd0) ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= 2'd2;
      end
    end
  end

  // Tag/target payload: any taken update either refreshes a hit (same tag)
  // or allocates, so both cases collapse to one unconditional write.
  always_ff @(posedge clock) begin
    if (!reset && upd_valid && upd_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
    end
  end

  // Registered prediction; holds its last value when no request arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid <= req_valid;
      if (req_valid) begin
        pred_taken  <= req_pred;
        pred_target <= req_pred ? target_q[req_idx] : req_pc + 32'd4;
      end
    end
  end

  // Registered one-cycle redirect on misprediction.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_valid <= 1'b0;
      flush_pc    <= '0;
    end else begin
      flush_valid <= mispred;
      if (mispred) flush_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
    end
  end

`ifdef YSYX_23060240_BPU_PERF_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_lookups  <= '0;
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      if (req_valid) perf_lookups  <= perf_lookups + 32'd1;
      if (upd_valid) perf_branches <= perf_branches + 32'd1;
      if (mispred)   perf_mispred  <= perf_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060240_bpu.sv
// Testbench for ysyx_23060240_bpu: directed scenarios followed by random
// traffic, checked against a behavioural table model every cycle.
module tb_ysyx_23060240_bpu;

  localparam int unsigned NE = 16;
  localparam int unsigned IW = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush_valid;
  logic [31:0] flush_pc;
`ifdef YSYX_23060240_BPU_PERF_EN
  logic [31:0] perf_lookups;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispred;
`endif

  ysyx_23060240_bpu #(.ENTRIES(NE)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_pc          (req_pc),
    .pred_valid      (pred_valid),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
`ifdef YSYX_23060240_BPU_PERF_EN
    .perf_lookups    (perf_lookups),
    .perf_branches   (perf_branches),
    .perf_mispred    (perf_mispred),
`endif
    .flush_valid     (flush_valid),
    .flush_pc        (flush_pc)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference tables
  bit          mv   [NE];
  logic [31:0] mtag [NE];
  logic [31:0] mtgt [NE];
  int          mctr [NE];
  int unsigned m_lk, m_br, m_mp;

  logic        e_pv, e_pt, e_fv;
  logic [31:0] e_ptg, e_fpc;
  bit          chk_fpc;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % NE;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (2 + IW);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return mv[idx_of(pc)] && (mtag[idx_of(pc)] == tag_of(pc));
  endfunction

  // Advance the reference by one clock edge using current inputs.
  task automatic model_step();
    bit mis;
    int unsigned li, ui;
    if (reset) begin
      for (int i = 0; i < NE; i++) begin mv[i] = 0; mctr[i] = 1; end
      e_pv = 0; e_pt = 0; e_ptg = '0; e_fv = 0; e_fpc = '0; chk_fpc = 1;
      m_lk = 0; m_br = 0; m_mp = 0;
    end else begin
      e_pv = req_valid;
      if (req_valid) begin
        li = idx_of(req_pc);
        e_pt = m_hit(req_pc) && (mctr[li] >= 2);
        e_ptg = e_pt ? mtgt[li] : req_pc + 32'd4;
        m_lk++;
      end
      mis = upd_valid && ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
      e_fv = mis;
      chk_fpc = mis;
      if (mis) begin
        e_fpc = upd_taken ? upd_target : upd_pc + 32'd4;
        m_mp++;
      end
      if (upd_valid) begin
        m_br++;
        ui = idx_of(upd_pc);
        if (m_hit(upd_pc)) begin
          if (upd_taken) begin
            mctr[ui] = (mctr[ui] < 3) ? mctr[ui] + 1 : 3;
            mtgt[ui] = upd_target;
          end else begin
            mctr[ui] = (mctr[ui] > 0) ? mctr[ui] - 1 : 0;
          end
        end else if (upd_taken) begin
          mv[ui] = 1; mtag[ui] = tag_of(upd_pc); mtgt[ui] = upd_target; mctr[ui] = 2;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    chk("pred_valid", {31'd0, pred_valid}, {31'd0, e_pv});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
    chk("pred_target", pred_target, e_ptg);
    chk("flush_valid", {31'd0, flush_valid}, {31'd0, e_fv});
    if (chk_fpc) chk("flush_pc", flush_pc, e_fpc);
`ifdef YSYX_23060240_BPU_PERF_EN
    chk("perf_lookups", perf_lookups, m_lk);
    chk("perf_branches", perf_branches, m_br);
    chk("perf_mispred", perf_mispred, m_mp);
`endif
  endtask

  task automatic drive(input bit rv, input logic [31:0] rpc, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utg,
                       input bit upt, input logic [31:0] uptg);
    req_valid = rv; req_pc = rpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
  endtask

  task automatic look(input logic [31:0] pc);
    drive(1, pc, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tg,
                     input bit pt, input logic [31:0] ptg);
    drive(0, '0, 1, pc, t, tg, pt, ptg);
  endtask

  initial begin
    logic [31:0] pc, tg, ptg;
    bit t, pt;
    int unsigned ui;

    reset = 1'b1;
    drive(0, '0, 0, '0, 0, '0, 0, '0);
    cycle();
    cycle();
    reset = 1'b0;

    // Cold lookup
    look(32'h8000_0000); cycle();
    chk("tp_cold_taken", {31'd0, pred_taken}, 32'd0);
    chk("tp_cold_target", pred_target, 32'h8000_0004);

    // Allocate with mispredict, then hit
    upd(32'h8000_0010, 1, 32'h8000_0100, 0, 32'h8000_0014); cycle();
    chk("tp_alloc_flush_pc", flush_pc, 32'h8000_0100);
    look(32'h8000_0010); cycle();
    chk("tp_hit_target", pred_target, 32'h8000_0100);

    // Counter 2 -> 1 -> 0, then predict not taken
    upd(32'h8000_0010, 0, '0, 1, 32'h8000_0100); cycle();
    upd(32'h8000_0010, 0, '0, 0, 32'h8000_0014); cycle();
    look(32'h8000_0010); cycle();
    chk("tp_nt_target", pred_target, 32'h8000_0014);

    // Four taken updates saturate at 3; two not-taken then reach 1
    for (int i = 0; i < 4; i++) begin
      upd(32'h8000_0010, 1, 32'h8000_0100, 0, 32'h8000_0014); cycle();
    end
    upd(32'h8000_0010, 0, '0, 1, 32'h8000_0100); cycle();
    look(32'h8000_0010); cycle();
    upd(32'h8000_0010, 0, '0, 1, 32'h8000_0100); cycle();
    look(32'h8000_0010); cycle();

    // Alias overwrites the entry
    upd(32'h8000_0010 + 4 * NE, 1, 32'h8000_0200, 0, 32'h8000_0054); cycle();
    look(32'h8000_0010); cycle();
    chk("tp_alias_miss", pred_target, 32'h8000_0014);
    look(32'h8000_0010 + 4 * NE); cycle();
    chk("tp_alias_hit", pred_target, 32'h8000_0200);

    // Same-cycle lookup and allocation: no bypass
    drive(1, 32'h8000_0020, 1, 32'h8000_0020, 1, 32'h8000_0300, 0, 32'h8000_0024); cycle();
    chk("tp_nobypass", pred_target, 32'h8000_0024);
    look(32'h8000_0020); cycle();
    chk("tp_after_alloc", pred_target, 32'h8000_0300);

    // Right direction, wrong target; then fully correct
    upd(32'h8000_0020, 1, 32'h8000_0300, 1, 32'h8000_0400); cycle();
    chk("tp_tgt_mis_pc", flush_pc, 32'h8000_0300);
    upd(32'h8000_0020, 1, 32'h8000_0300, 1, 32'h8000_0300); cycle();

    // Address wrap
    look(32'hFFFF_FFFC); cycle();
    chk("tp_wrap_target", pred_target, 32'h0000_0000);
    upd(32'hFFFF_FFFC, 0, '0, 1, 32'h1234_5678); cycle();
    chk("tp_wrap_flush", flush_pc, 32'h0000_0000);

    // Reset while a flush is pending
    upd(32'h8000_0040, 1, 32'h8000_0500, 0, 32'h8000_0044);
    reset = 1'b1; cycle(); reset = 1'b0;
    look(32'h8000_0020); cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      req_valid = $urandom_range(0, 3) != 0;
      req_pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                                             : 32'h8000_0000 + ($urandom_range(0, 47) << 2);
      pc = 32'h8000_0000 + ($urandom_range(0, 47) << 2);
      t = $urandom_range(0, 1);
      tg = 32'h8000_1000 + ($urandom_range(0, 3) << 4);
      ui = idx_of(pc);
      pt = m_hit(pc) && (mctr[ui] >= 2);
      ptg = pt ? mtgt[ui] : pc + 32'd4;
      case ($urandom_range(0, 3))
        0: pt = !pt;
        1: ptg = 32'h8000_1000 + ($urandom_range(0, 3) << 4);
        default: ;
      endcase
      upd_valid = $urandom_range(0, 2) != 0;
      upd_pc = pc; upd_taken = t; upd_target = tg;
      upd_pred_taken = pt; upd_pred_target = ptg;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
